// File: rtl/pc_sequencer.sv
// Program counter sequencer: stall, prioritised redirects, circular RAS, EPC.
// Optional: PC_SEQUENCER_MISALIGN_TRAP_EN turns misaligned targets into traps.
module pc_sequencer #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] TRAP_PC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              jump_en,
  input  logic              jump_link,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              ret_en,
  input  logic              trap_en,
  input  logic              eret_en,
  output logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] epc,
  output logic              in_trap,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow,
  output logic [ADDR_W-1:0] badaddr
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] TRP_PC = TRAP_PC[ADDR_W-1:0];
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              trap_q, trap_d;
  logic              uf_q, uf_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              push, pop, trap_go, misalign;
  logic [ADDR_W-1:0] tgt_al, link_pc, top;

  assign tgt_al  = {jump_target[ADDR_W-1:2], 2'b00};
  assign link_pc = pc_q + ADDR_W'(4);
  assign top     = ras_q[ptr_q - PW'(1)];

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
  assign misalign = |jump_target[1:0];
`else
  logic unused_lo;
  assign unused_lo = ^jump_target[1:0];
  assign misalign  = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q + ADDR_W'(4);
    epc_d   = epc_q;
    trap_d  = trap_q;
    uf_d    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    trap_go = 1'b0;
    if (trap_en) begin
      trap_go = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret_en && trap_q) begin
      pc_d   = epc_q;
      trap_d = 1'b0;
    end else if (ret_en) begin
      if (cnt_q != '0) begin
        pc_d = top;
        pop  = 1'b1;
      end else begin
        uf_d    = 1'b1;
        pc_d    = tgt_al;
        trap_go = misalign;
      end
    end else if (jump_en) begin
      pc_d    = tgt_al;
      trap_go = misalign;
      push    = jump_link && !misalign;
    end
    // Nested traps keep the EPC of the outermost handler entry
    if (trap_go) begin
      pc_d = TRP_PC;
      if (!trap_q) begin
        epc_d  = {pc_q[ADDR_W-1:2], 2'b00};
        trap_d = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RST_PC;
      epc_q  <= '0;
      trap_q <= 1'b0;
      uf_q   <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      trap_q <= trap_d;
      uf_q   <= uf_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else if (push) begin
      ras_q[ptr_q] <= {link_pc[ADDR_W-1:2], 2'b00};
    end
  end

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
  logic [ADDR_W-1:0] bad_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bad_q <= '0;
    else if (trap_go && !trap_en) bad_q <= jump_target;
  end
  assign badaddr = bad_q;
`else
  assign badaddr = '0;
`endif

  assign pc_value      = pc_q;
  assign epc           = epc_q;
  assign in_trap       = trap_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == FULL_CNT);
  assign ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan steps plus random traffic vs a model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, jump_en, jump_link, ret_en, trap_en, eret_en;
  logic [31:0] jt;
  logic [31:0] pc, epc, bad;
  logic        in_trap, empty, full, uf;
  logic [15:0] pc16, epc16, bad16;
  logic        in_trap16, empty16, full16, uf16;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_trap, m_uf;
  logic [31:0] m_ras [$];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .jump_en(jump_en), .jump_link(jump_link),
    .jump_target(jt), .ret_en(ret_en),
    .trap_en(trap_en), .eret_en(eret_en),
    .pc_value(pc), .epc(epc), .in_trap(in_trap),
    .ras_empty(empty), .ras_full(full),
    .ras_underflow(uf), .badaddr(bad)
  );

  pc_sequencer #(.ADDR_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .jump_en(jump_en), .jump_link(jump_link),
    .jump_target(jt[15:0]), .ret_en(ret_en),
    .trap_en(trap_en), .eret_en(eret_en),
    .pc_value(pc16), .epc(epc16), .in_trap(in_trap16),
    .ras_empty(empty16), .ras_full(full16),
    .ras_underflow(uf16), .badaddr(bad16)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".trap"}, 32'(in_trap), 32'(m_trap));
    check({tag, ".uf"}, 32'(uf), 32'(m_uf));
    check({tag, ".empty"}, 32'(empty), 32'(m_ras.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(m_ras.size() == 4));
    check({tag, ".bad"}, bad, 32'h0);
  endtask

  task automatic model_reset();
    m_pc = 32'h3000;
    m_epc = 0;
    m_trap = 0;
    m_uf = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] old = m_pc;
    m_uf = 0;
    if (trap_en) begin
      m_pc = 32'h4180;
      if (!m_trap) begin
        m_epc = old;
        m_trap = 1;
      end
    end else if (stall) begin
      m_pc = old;
    end else if (eret_en && m_trap) begin
      m_pc = m_epc;
      m_trap = 0;
    end else if (ret_en) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = jt & ~32'h3;
        m_uf = 1;
      end
    end else if (jump_en) begin
      if (jump_link) begin
        m_ras.push_back(old + 4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = jt & ~32'h3;
    end else begin
      m_pc = old + 4;
    end
  endtask

  task automatic drive(input logic s, input logic j, input logic l,
                       input logic [31:0] t, input logic r,
                       input logic tr, input logic e);
    stall = s; jump_en = j; jump_link = l; jt = t;
    ret_en = r; trap_en = tr; eret_en = e;
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    check("rel.pc", pc, 32'h3000);
    for (int i = 1; i <= 3; i++) begin
      step("free");
      check("free.const", pc, 32'h3000 + 32'(4 * i));
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst.pc", pc, 32'h3000);
    check_model("midrst");
    @(negedge clk);
    reset_n = 1'b1;

    drive(0, 1, 1, 32'h6000, 0, 0, 0); step("call");
    check("call.pc", pc, 32'h6000);
    drive(0, 0, 0, 0, 1, 0, 0); step("ret");
    check("ret.pc", pc, 32'h3004);

    drive(0, 1, 0, 32'h5002, 0, 0, 0); step("mis");
    check("mis.pc", pc, 32'h5000);

    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 32'h8000 + 32'(i * 256), 0, 0, 0);
      step("ncall");
    end
    check("ncall.full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0); step("nret");
      check("nret.pc", pc, 32'h8304 - 32'(i * 256));
    end
    drive(0, 0, 0, 32'h7000, 1, 0, 0); step("uflow");
    check("uflow.pulse", 32'(uf), 32'd1);
    check("uflow.pc", pc, 32'h7000);
    step("uflow.clr");
    check("uflow.clr", 32'(uf), 32'd0);

    drive(0, 1, 1, 32'h3010, 0, 0, 0); step("to3010");
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0); step("stall");
      check("stall.pc", pc, 32'h3010);
    end
    drive(1, 0, 0, 0, 0, 1, 0); step("trapstall");
    check("trap.pc", pc, 32'h4180);
    check("trap.epc", epc, 32'h3010);
    step("handler");
    drive(0, 1, 1, 32'h9000, 1, 1, 0); step("nested");
    check("nested.pc", pc, 32'h4180);
    check("nested.epc", epc, 32'h3010);
    check("nested.ras", 32'(empty), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1); step("eret");
    check("eret.pc", pc, 32'h3010);
    check("eret.trap", 32'(in_trap), 32'd0);
    drive(0, 0, 0, 0, 1, 0, 0); step("ret2");
    check("ret2.pc", pc, 32'h7008);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99) < 15, $urandom_range(99) < 25,
            $urandom_range(1), $urandom,
            $urandom_range(99) < 15, $urandom_range(99) < 5,
            $urandom_range(99) < 10);
      step("rand");
    end

    do_reset();
    drive(0, 1, 0, 32'h0000_FFFC, 0, 0, 0); step("w16a");
    check("w16.pc_a", 32'(pc16), 32'h0000_FFFC);
    step("w16b");
    check("w16.pc_b", 32'(pc16), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the single-cycle/multi-cycle CPU front end.
- Adds the following over the basic counter:
  - pipeline stall
  - priority-resolved redirect sources: jump, call, return, trap, exception-return
  - a circular return-address stack (RAS)
  - an exception PC register
- Output pc_value feeds instruction memory; redirect inputs come from decode/execute and the exception controller.

Parameters:
ADDR_W, 32, PC/address width in bits (>= 8)
RESET_PC, 32'h0000_3000, value loaded on reset (truncated to ADDR_W)
TRAP_PC, 32'h0000_4180, trap handler entry address
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS this cycle (trap still honoured)
jump_en  in  1  redirect to jump_target
jump_link  in  1  with jump_en: call; push pc_value+4 onto RAS
jump_target  in  ADDR_W  jump/return-fallback target
ret_en  in  1  return: pop RAS into PC
trap_en  in  1  exception entry
eret_en  in  1  exception return
pc_value  out  ADDR_W  current PC (registered)
epc  out  ADDR_W  saved exception PC (registered)
in_trap  out  1  handler active flag
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == RAS_DEPTH
ras_underflow  out  1  one-cycle pulse: ret_en with empty RAS
badaddr  out  ADDR_W  last misaligned target (macro only, else 0)

Behaviour:
- Reset (reset_n low, async):
  - pc_value=RESET_PC, epc=0, in_trap=0, badaddr=0, ras_underflow=0
  - RAS count=0, RAS pointer=0
- State updates only on posedge clk. All outputs are registered. A redirect is visible on pc_value the cycle after the request (1-cycle latency).
- Request priority per cycle (highest first):
  1. trap_en:
     - pc <= TRAP_PC
     - if in_trap==0: epc <= pc_value and in_trap <= 1
     - nested trap (in_trap==1): epc unchanged
     - applies even when stall=1
  2. stall: pc, RAS, epc, in_trap hold. ras_underflow <= 0.
  3. eret_en and in_trap:
     - pc <= epc, in_trap <= 0
     - eret_en with in_trap==0 is ignored (falls through to lower priorities)
  4. ret_en:
     - RAS non-empty: pc <= top entry, pop (count-1)
     - RAS empty: pc <= aligned jump_target, ras_underflow <= 1
  5. jump_en:
     - pc <= {jump_target[ADDR_W-1:2], 2'b00}
     - if jump_link: push (pc_value+4)
  6. Otherwise: pc <= pc_value + 4, modulo 2^ADDR_W (all-ones-minus-3 wraps to 0).
- Simultaneous requests: lower-priority ones are dropped entirely (no RAS push/pop from a dropped request).
- RAS is a circular buffer.
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH.
  - Pop returns the most recent push.
  - A trap never modifies the RAS.
- Alignment: all loaded targets have bits [1:0] forced to 0. epc and RAS entries are always aligned.
- ras_underflow is a pulse that clears the next non-underflow cycle.
- Reset asserted mid-operation: immediate return to reset values. The first fetch after release is RESET_PC.

Optional Feature:
Macro: PC_SEQUENCER_MISALIGN_TRAP_EN
- Defined:
  - A jump_en (or empty-RAS ret_en) whose target has bits [1:0] != 0 is converted into a trap with the same epc/in_trap rules as trap_en.
  - No RAS push occurs.
  - badaddr <= the raw target.
- Undefined:
  - Targets are silently aligned.
  - badaddr is tied to 0.

Test Plan:
1. Reset release, 3 free-running cycles -> pc_value 0x3000, 0x3004, 0x3008, 0x300C. Assert reset_n low mid-cycle -> pc_value 0x3000 immediately, without waiting for a clock edge.
2. Jump to 0x0000_5002 (misaligned), macro off -> pc 0x5000. Macro on -> pc 0x4180, epc=prior pc, badaddr 0x5002.
3. Call at pc 0x3000 to 0x6000, then ret_en -> pc 0x6000 then 0x3004. Five nested calls with RAS_DEPTH=4, then 5 returns:
   - first 4 returns pop the four most recent return addresses
   - 5th return: ras_underflow pulses, pc = jump_target
4. stall=1 for 3 cycles at pc 0x3010 -> pc holds 0x3010. trap_en during stall -> pc 0x4180, epc 0x3010. eret_en -> pc 0x3010, in_trap 0.
5. Same cycle trap_en+jump_en+ret_en -> pc 0x4180, RAS count unchanged. Nested trap at 0x4184 -> epc stays 0x3010.
6. ADDR_W=16, pc 0xFFFC, no requests -> next pc 0x0000.
